whack_judge: RTL and testbench
==============================

# whack_judge

Game-round controller and hit judge for the whack-a-mole display path. Drives `trigger` to the mole generator, captures the one-hot `displayL` pattern it returns, watches the 18 player switches for the matching toggle, then scores hit or miss per round. Sits between the player switch inputs and the mole/LED generator; its `score` feeds the HEX display logic.

## Interface
- `TIMEOUT`, 50_000_000: cycles a mole stays lit before the round is a miss (≥2).
- `GAP`, 12_500_000: cycles `trigger` is held low between rounds (≥2).
- `ROUNDS`, 20: rounds per game (1..255).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level; sampled high in IDLE/DONE starts a game.
- `sw` in 18: raw player switches, asynchronous to `clk`.
- `displayL` in 18: one-hot lit mole from the generator; valid one cycle after `trigger` rises.
- `trigger` out 1: registered; high while a mole must be shown.
- `hit` out 1: one-cycle pulse, correct switch toggled.
- `miss` out 1: one-cycle pulse, wrong switch or timeout.
- `score` out 8: saturating score.
- `streak` out 4: consecutive hits, saturating at 15.
- `busy` out 1: high from game start until DONE.
- `done` out 1: high in DONE until next start or reset.

## Operation
- `sw` passes through a 2-flop synchronizer per bit; rising-edge vector `edge = sync & ~sync_d`.
- FSM states: IDLE, ARM, CAPTURE, WAIT, RESULT, GAP, DONE.
- IDLE: `start`=1 → clear `score`, `streak`, round counter → ARM.
- ARM (1 cycle): `trigger`←1 → CAPTURE.
- CAPTURE (1 cycle): latch `target = displayL`. If `target` not exactly one bit set → round void: no pulse, round not counted, → GAP. Else load timeout counter with TIMEOUT-1 → WAIT.
- WAIT: each cycle evaluate `edge`:
  - any `edge & ~target` bit set → miss (wrong wins even if the target bit toggled the same cycle).
  - else `edge & target` set → hit.
  - else counter at 0 → miss (timeout); else decrement.
- RESULT (1 cycle): `trigger`←0; assert `hit` or `miss`; update `score`/`streak`; increment round count → GAP.
- Hit: `streak` += 1 (sat 15); `score` += 1. Miss: `streak` ← 0, `score` unchanged.
- `score` saturates at 255; never wraps.
- GAP: hold `trigger` low for GAP cycles; then round count == ROUNDS → DONE, else ARM.
- DONE: `done`=1, `busy`=0, `score` held; `start`=1 → behaves as IDLE start.
- `start` outside IDLE/DONE ignored. Switch edges outside WAIT ignored (not queued).

## Timing
- Reset (async): state IDLE; `trigger`, `hit`, `miss`, `busy`, `done` = 0; `score`, `streak`, counters = 0; synchronizer flops = 0.
- `start` sampled at edge k → `trigger` high after edge k+1 (ARM); `target` latched at edge k+2.
- Switch rises before edge t and is stable → `sync` high after t+1, `edge` seen in WAIT at t+1, `hit`/`miss` high for the cycle after edge t+2.
- Timeout: `miss` pulses exactly TIMEOUT+1 cycles after CAPTURE ends.
- `trigger` low exactly GAP+1 cycles between rounds (RESULT + GAP).
- `hit` and `miss` never high together; at most one pulse per round.
- Reset mid-round: `trigger` drops immediately; no pulse; score lost.

## Configuration
- `WHACK_STREAK_BONUS_EN` defined: a hit with pre-increment `streak` ≥ 3 adds 2 to `score` (still saturating at 255).
- Undefined: every hit adds 1; `streak` still counts and is output.

## Test plan
- TIMEOUT=16, GAP=4, ROUNDS=3; `start` pulse; generator returns `displayL`=18'h00010; toggle `sw[4]` 5 cycles into WAIT → one `hit`, `score`=1, `streak`=1, `trigger` low for 5 cycles, then next ARM.
- Same config, no switch activity for 3 rounds → 3 `miss` pulses, each TIMEOUT+1 cycles after CAPTURE; `score`=0, `done`=1 after third GAP.
- `displayL`=18'h00010, `sw[4]` and `sw[7]` rise in the same cycle → `miss`, `streak`=0.
- `displayL`=18'h00000 (and separately 18'h00003) in CAPTURE → no pulse, round not counted, game takes 4 ARM cycles for ROUNDS=3.
- ROUNDS=255, every round hit → `score` saturates at 255 (macro undefined); with `WHACK_STREAK_BONUS_EN`, after 5 hits `score`=1+1+1+2+2=7.
- Assert `reset` during WAIT with `trigger` high → `trigger`, `score`, `busy` = 0 without waiting for a clock edge; no `hit`/`miss` afterwards.

Source files
------------

// File: rtl/whack_judge.sv
// whack_judge: round sequencer and hit judge between the player switches and the mole generator.
// Optional feature macro WHACK_STREAK_BONUS_EN: a hit on a running streak of 3 or more scores 2 points.
module whack_judge #(
    parameter int TIMEOUT = 50_000_000,
    parameter int GAP     = 12_500_000,
    parameter int ROUNDS  = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] sw,
    input  logic [17:0] displayL,
    output logic        trigger,
    output logic        hit,
    output logic        miss,
    output logic [7:0]  score,
    output logic [3:0]  streak,
    output logic        busy,
    output logic        done
);
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX);

    // IDLE wait start | ARM raise trigger | CAPTURE latch target | WAIT judge switches
    // RESULT pulse + score | GAP trigger held low | DONE hold score until start
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAPTURE, S_WAIT, S_RESULT, S_GAP, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [17:0]   sw_meta, sw_sync, sw_sync_d, sw_rise, target;
    logic [CW-1:0] cnt;
    logic [7:0]    rounds_done;
    logic          res_hit, one_hot, wrong, right, cnt_zero;
    logic [1:0]    score_inc;
    logic [8:0]    score_sum;

    assign sw_rise  = sw_sync & ~sw_sync_d;
    assign wrong    = |(sw_rise & ~target);
    assign right    = |(sw_rise & target);
    assign one_hot  = (displayL != '0) && ((displayL & (displayL - 18'd1)) == '0);
    assign cnt_zero = (cnt == '0);

`ifdef WHACK_STREAK_BONUS_EN
    assign score_inc = (streak >= 4'd3) ? 2'd2 : 2'd1;
`else
    assign score_inc = 2'd1;
`endif
    assign score_sum = {1'b0, score} + {7'b0, score_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_ARM;
            S_ARM:          state_nx = S_CAPTURE;
            S_CAPTURE:      state_nx = one_hot ? S_WAIT : S_GAP;
            S_WAIT:         if (wrong || right || cnt_zero) state_nx = S_RESULT;
            S_RESULT:       state_nx = S_GAP;
            S_GAP:          if (cnt_zero) state_nx = (rounds_done == 8'(ROUNDS)) ? S_DONE : S_ARM;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            sw_sync_d   <= '0;
            target      <= '0;
            cnt         <= '0;
            rounds_done <= '0;
            res_hit     <= 1'b0;
            trigger     <= 1'b0;
            score       <= '0;
            streak      <= '0;
        end else begin
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
            sw_sync_d <= sw_sync;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        score       <= '0;
                        streak      <= '0;
                        rounds_done <= '0;
                    end
                end
                S_ARM: trigger <= 1'b1;
                S_CAPTURE: begin
                    target <= displayL;
                    if (one_hot) begin
                        cnt <= CW'(TIMEOUT - 1);
                    end else begin
                        // void round: straight to the gap without counting it
                        cnt     <= CW'(GAP - 1);
                        trigger <= 1'b0;
                    end
                end
                S_WAIT: begin
                    res_hit <= right & ~wrong;
                    if (!(wrong || right || cnt_zero)) cnt <= cnt - 1'b1;
                end
                S_RESULT: begin
                    trigger     <= 1'b0;
                    cnt         <= CW'(GAP - 1);
                    rounds_done <= rounds_done + 8'd1;
                    if (res_hit) begin
                        score  <= score_sum[8] ? 8'hFF : score_sum[7:0];
                        streak <= (streak == 4'hF) ? streak : streak + 4'd1;
                    end else begin
                        streak <= '0;
                    end
                end
                S_GAP: if (!cnt_zero) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign hit  = (state == S_RESULT) && res_hit;
    assign miss = (state == S_RESULT) && !res_hit;
    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_whack_judge.sv
// Bench for whack_judge: table-driven rounds on a short-timer instance plus a 255-round
// saturation run on a second instance; pulses are matched against a queue of expected results.
module tb_whack_judge;
    localparam int T  = 16;
    localparam int G  = 4;
    localparam int R  = 3;
    localparam int ST = 8;
    localparam int SG = 2;
`ifdef WHACK_STREAK_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, trigger, hit, miss, busy, done;
    logic [17:0] sw, disp;
    logic [7:0]  score;
    logic [3:0]  streak;

    logic        s_start, s_trigger, s_hit, s_miss, s_busy, s_done;
    logic [17:0] s_sw, s_disp;
    logic [7:0]  s_score;
    logic [3:0]  s_streak;

    whack_judge #(.TIMEOUT(T), .GAP(G), .ROUNDS(R)) dut (
        .clk(clk), .reset(reset), .start(start), .sw(sw), .displayL(disp),
        .trigger(trigger), .hit(hit), .miss(miss), .score(score), .streak(streak),
        .busy(busy), .done(done)
    );

    whack_judge #(.TIMEOUT(ST), .GAP(SG), .ROUNDS(255)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .sw(s_sw), .displayL(s_disp),
        .trigger(s_trigger), .hit(s_hit), .miss(s_miss), .score(s_score), .streak(s_streak),
        .busy(s_busy), .done(s_done)
    );

    typedef struct {
        logic [17:0] disp;
        logic [17:0] mask;
        int          dly;
        int          kind;   // 0 miss, 1 hit, 2 void
    } vec_t;

    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];
    bit   s_exp_q[$];
    int   m_score, m_streak, counted, arms, voids;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void upd(input bit h, inout int sc, inout int st);
        if (h) begin
            sc = sc + ((BONUS && st >= 3) ? 2 : 1);
            if (sc > 255) sc = 255;
            if (st < 15) st++;
        end else begin
            st = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (hit === 1'b1 || miss === 1'b1) begin
            check("hit_miss_exclusive", int'(hit & miss), 0);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b expected none", hit, miss);
            end else begin
                bit e;
                e = exp_q.pop_front();
                check("pulse_kind_hit", int'(hit), int'(e));
            end
        end
        if (s_hit === 1'b1 || s_miss === 1'b1) begin
            if (s_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sat_unexpected_pulse: hit=%0b miss=%0b expected none", s_hit, s_miss);
            end else begin
                bit e;
                e = s_exp_q.pop_front();
                check("sat_pulse_kind_hit", int'(s_hit), int'(e));
            end
        end
    end

    // Entry: first=1 at any negedge in IDLE/DONE; otherwise at the first negedge with trigger low.
    // Exit: first negedge of the following GAP.
    task automatic play_round(input vec_t v, input bit first);
        int n, lat;
        if (first) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("arm_trigger_low", int'(trigger), 0);
            check("busy_after_start", int'(busy), 1);
            check("done_after_start", int'(done), 0);
            @(negedge clk);
            check("start_to_trigger", int'(trigger), 1);
        end else begin
            n = 0;
            while (trigger !== 1'b1 && n < 40) begin
                n++;
                // switch activity during the gap must never score
                if (n == 1) sw = '1;
                else if (n == 2) sw = '0;
                @(negedge clk);
            end
            check("trigger_low_cycles", n, G + 1);
        end
        arms++;
        disp = v.disp;
        if (v.kind != 2 && v.mask == '0) exp_q.push_back(1'b0);
        @(negedge clk);
        if (v.kind == 2) begin
            voids++;
            check("void_trigger_low", int'(trigger), 0);
            disp = '0;
            return;
        end
        lat = 1;
        while (!(hit === 1'b1 || miss === 1'b1) && lat < T + 10) begin
            if (v.mask != '0 && lat == v.dly) begin
                sw = v.mask;
                exp_q.push_back(v.kind == 1);
            end
            @(negedge clk);
            lat++;
        end
        check("pulse_latency", lat, (v.mask == '0) ? T + 1 : v.dly + 3);
        upd(v.kind == 1, m_score, m_streak);
        counted++;
        @(negedge clk);
        sw   = '0;
        disp = '0;
        check("score_after_round", int'(score), m_score);
        check("streak_after_round", int'(streak), m_streak);
    endtask

    task automatic finish_game();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", n, G);
        check("busy_in_done", int'(busy), 0);
        check("score_at_done", int'(score), m_score);
        check("arm_count", arms, R + voids);
        repeat (3) @(negedge clk);
        check("done_held", int'(done), 1);
        check("score_held", int'(score), m_score);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{18'h00010, 18'h00010, 5, 1};
        tbl[1]  = '{18'h00010, 18'h00090, 3, 0};
        tbl[2]  = '{18'h00000, 18'h00000, 0, 2};
        tbl[3]  = '{18'h00003, 18'h00000, 0, 2};
        tbl[4]  = '{18'h20000, 18'h20000, 14, 1};
        tbl[5]  = '{18'h00100, 18'h00000, 0, 0};
        tbl[6]  = '{18'h00001, 18'h00000, 0, 0};
        tbl[7]  = '{18'h20000, 18'h00000, 0, 0};
        tbl[8]  = '{18'h00001, 18'h00001, 1, 1};
        tbl[9]  = '{18'h00200, 18'h00200, 2, 1};
        tbl[10] = '{18'h08000, 18'h08000, 4, 1};

        reset = 1'b1;
        start = 1'b0; sw = '0; disp = '0;
        s_start = 1'b0; s_sw = '0; s_disp = '0;
        repeat (3) @(negedge clk);
        check("reset_trigger", int'(trigger), 0);
        check("reset_hit", int'(hit), 0);
        check("reset_miss", int'(miss), 0);
        check("reset_score", int'(score), 0);
        check("reset_streak", int'(streak), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        counted = 0;
        for (int i = 0; i < 11; i++) begin
            bit first;
            first = (counted == 0);
            if (first) begin
                m_score = 0; m_streak = 0; arms = 0; voids = 0;
            end
            play_round(tbl[i], first);
            if (counted == R) begin
                finish_game();
                counted = 0;
            end
        end

        // reset in the middle of a round that follows a scored hit
        m_score = 0; m_streak = 0; arms = 0; voids = 0; counted = 0;
        play_round('{18'h00010, 18'h00010, 2, 1}, 1'b1);
        n = 0;
        while (trigger !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        disp = 18'h00010;
        repeat (3) @(negedge clk);
        check("trigger_before_reset", int'(trigger), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_trigger", int'(trigger), 0);
        check("async_reset_score", int'(score), 0);
        check("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        disp  = '0;
        repeat (30) @(negedge clk);
        check("idle_after_reset", int'(busy), 0);
        check("no_pending_pulses", exp_q.size(), 0);

        // 255 straight hits on the saturation instance
        begin
            int sc, st;
            sc = 0; st = 0;
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            for (int r = 1; r <= 255; r++) begin
                n = 0;
                while (s_trigger !== 1'b1 && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                s_disp = 18'h00001;
                @(negedge clk);
                s_sw = 18'h00001;
                s_exp_q.push_back(1'b1);
                n = 0;
                while (!(s_hit === 1'b1 || s_miss === 1'b1) && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 20) check("sat_pulse_timeout", n, 3);
                upd(1'b1, sc, st);
                @(negedge clk);
                s_sw   = '0;
                s_disp = '0;
                check("sat_score", int'(s_score), sc);
                check("sat_streak", int'(s_streak), st);
            end
            n = 0;
            while (s_done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("sat_done", int'(s_done), 1);
            check("sat_final_score", int'(s_score), 255);
            check("sat_final_streak", int'(s_streak), 15);
            check("sat_no_pending", s_exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
